// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-bus owner: forwards the init sequencer until INIT_DONE, then arbitrates
// refresh (fixed priority) and write/read (round-robin), holding each grant until its END pulse.
module sdram_cmd_arbiter #(
    parameter int SDRAM_ADDR_WIDTH = 12,
    parameter int SDRAM_BANK_WIDTH = 2,
    parameter int REF_CYCLES       = 780
) (
    input  logic                        Sys_clk,
    input  logic                        Rst_n,
    input  logic                        INIT_DONE,
    input  logic [3:0]                  COMMAND_INIT,
    input  logic [SDRAM_ADDR_WIDTH-1:0] INIT_A_ADDR,
    input  logic [SDRAM_BANK_WIDTH-1:0] INIT_BANK_ADDR,
    input  logic [3:0]                  AREF_CMD,
    input  logic [SDRAM_ADDR_WIDTH-1:0] AREF_A_ADDR,
    input  logic [SDRAM_BANK_WIDTH-1:0] AREF_BANK_ADDR,
    input  logic [3:0]                  WR_CMD,
    input  logic [SDRAM_ADDR_WIDTH-1:0] WR_A_ADDR,
    input  logic [SDRAM_BANK_WIDTH-1:0] WR_BANK_ADDR,
    input  logic [3:0]                  RD_CMD,
    input  logic [SDRAM_ADDR_WIDTH-1:0] RD_A_ADDR,
    input  logic [SDRAM_BANK_WIDTH-1:0] RD_BANK_ADDR,
    input  logic                        WR_REQ,
    input  logic                        RD_REQ,
    input  logic                        AREF_END,
    input  logic                        WR_END,
    input  logic                        RD_END,
    output logic                        AREF_EN,
    output logic                        WR_EN,
    output logic                        RD_EN,
    output logic [3:0]                  SDRAM_CMD,
    output logic [SDRAM_ADDR_WIDTH-1:0] SDRAM_A_ADDR,
    output logic [SDRAM_BANK_WIDTH-1:0] SDRAM_BANK_ADDR
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam logic GNT_WRITE = 1'b0;
    localparam logic GNT_READ  = 1'b1;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam int TMR_W = $clog2(REF_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [TMR_W-1:0] ref_timer;
    logic             tmr_expire;
    logic             aref_pend;
    logic             last_grant;
    logic             enter_aref;

    assign tmr_expire = (state != S_INIT) && (ref_timer == TMR_LAST);
    assign enter_aref = (state == S_IDLE) && (state_nxt == S_AREF);

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (INIT_DONE)
                    state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (aref_pend)
                    state_nxt = S_AREF;
                else if (WR_REQ && RD_REQ)
                    state_nxt = (last_grant == GNT_READ) ? S_WRITE : S_READ;
                else if (WR_REQ)
                    state_nxt = S_WRITE;
                else if (RD_REQ)
                    state_nxt = S_READ;
            end
            S_AREF: begin
                if (AREF_END)
                    state_nxt = S_IDLE;
            end
            S_WRITE: begin
                if (WR_END)
                    state_nxt = S_IDLE;
            end
            S_READ: begin
                if (RD_END)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Grants are registered from the next state so they line up exactly with the grant states.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_INIT;
            AREF_EN    <= 1'b0;
            WR_EN      <= 1'b0;
            RD_EN      <= 1'b0;
            last_grant <= GNT_READ;
        end else begin
            state   <= state_nxt;
            AREF_EN <= (state_nxt == S_AREF);
            WR_EN   <= (state_nxt == S_WRITE);
            RD_EN   <= (state_nxt == S_READ);
            if (state == S_IDLE && state_nxt == S_WRITE)
                last_grant <= GNT_WRITE;
            else if (state == S_IDLE && state_nxt == S_READ)
                last_grant <= GNT_READ;
        end
    end

    // A timer expiry coinciding with refresh entry keeps the request pending.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ref_timer <= '0;
            aref_pend <= 1'b0;
        end else begin
            if (state == S_INIT || tmr_expire)
                ref_timer <= '0;
            else
                ref_timer <= ref_timer + 1'b1;

            if (tmr_expire)
                aref_pend <= 1'b1;
            else if (enter_aref)
                aref_pend <= 1'b0;
        end
    end

    always_comb begin
        SDRAM_CMD       = CMD_NOP;
        SDRAM_A_ADDR    = '0;
        SDRAM_BANK_ADDR = '0;
        case (state)
            S_INIT: begin
                SDRAM_CMD       = COMMAND_INIT;
                SDRAM_A_ADDR    = INIT_A_ADDR;
                SDRAM_BANK_ADDR = INIT_BANK_ADDR;
            end
            S_AREF: begin
                SDRAM_CMD       = AREF_CMD;
                SDRAM_A_ADDR    = AREF_A_ADDR;
                SDRAM_BANK_ADDR = AREF_BANK_ADDR;
            end
            S_WRITE: begin
                SDRAM_CMD       = WR_CMD;
                SDRAM_A_ADDR    = WR_A_ADDR;
                SDRAM_BANK_ADDR = WR_BANK_ADDR;
            end
            S_READ: begin
                SDRAM_CMD       = RD_CMD;
                SDRAM_A_ADDR    = RD_A_ADDR;
                SDRAM_BANK_ADDR = RD_BANK_ADDR;
            end
            default: begin
                SDRAM_CMD       = CMD_NOP;
                SDRAM_A_ADDR    = '0;
                SDRAM_BANK_ADDR = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter with a short refresh period (REF_CYCLES=20).
module tb_sdram_cmd_arbiter;

    localparam int AW = 12;
    localparam int BW = 2;

    localparam logic [17:0] NOP_BUS  = {4'b0111, 2'd0, 12'h000};
    localparam logic [17:0] AREF_BUS = {4'b0001, 2'd2, 12'h222};
    localparam logic [17:0] WR_BUS   = {4'b0100, 2'd3, 12'h333};
    localparam logic [17:0] RD_BUS   = {4'b0101, 2'd0, 12'h444};

    logic          Sys_clk = 1'b0;
    logic          Rst_n;
    logic          INIT_DONE;
    logic [3:0]    COMMAND_INIT;
    logic [AW-1:0] INIT_A_ADDR;
    logic [BW-1:0] INIT_BANK_ADDR;
    logic [3:0]    AREF_CMD, WR_CMD, RD_CMD;
    logic [AW-1:0] AREF_A_ADDR, WR_A_ADDR, RD_A_ADDR;
    logic [BW-1:0] AREF_BANK_ADDR, WR_BANK_ADDR, RD_BANK_ADDR;
    logic          WR_REQ, RD_REQ, AREF_END, WR_END, RD_END;
    logic          AREF_EN, WR_EN, RD_EN;
    logic [3:0]    SDRAM_CMD;
    logic [AW-1:0] SDRAM_A_ADDR;
    logic [BW-1:0] SDRAM_BANK_ADDR;

    logic [2:0]  en;
    logic [17:0] bus;
    logic [17:0] init_bus;
    int total = 0;
    int bad   = 0;

    assign en       = {AREF_EN, WR_EN, RD_EN};
    assign bus      = {SDRAM_CMD, SDRAM_BANK_ADDR, SDRAM_A_ADDR};
    assign init_bus = {COMMAND_INIT, INIT_BANK_ADDR, INIT_A_ADDR};

    always #5 Sys_clk = ~Sys_clk;

    sdram_cmd_arbiter #(
        .SDRAM_ADDR_WIDTH(AW),
        .SDRAM_BANK_WIDTH(BW),
        .REF_CYCLES(20)
    ) dut (
        .Sys_clk(Sys_clk), .Rst_n(Rst_n), .INIT_DONE(INIT_DONE),
        .COMMAND_INIT(COMMAND_INIT), .INIT_A_ADDR(INIT_A_ADDR), .INIT_BANK_ADDR(INIT_BANK_ADDR),
        .AREF_CMD(AREF_CMD), .AREF_A_ADDR(AREF_A_ADDR), .AREF_BANK_ADDR(AREF_BANK_ADDR),
        .WR_CMD(WR_CMD), .WR_A_ADDR(WR_A_ADDR), .WR_BANK_ADDR(WR_BANK_ADDR),
        .RD_CMD(RD_CMD), .RD_A_ADDR(RD_A_ADDR), .RD_BANK_ADDR(RD_BANK_ADDR),
        .WR_REQ(WR_REQ), .RD_REQ(RD_REQ),
        .AREF_END(AREF_END), .WR_END(WR_END), .RD_END(RD_END),
        .AREF_EN(AREF_EN), .WR_EN(WR_EN), .RD_EN(RD_EN),
        .SDRAM_CMD(SDRAM_CMD), .SDRAM_A_ADDR(SDRAM_A_ADDR), .SDRAM_BANK_ADDR(SDRAM_BANK_ADDR)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    // Entry edge, hold cycles with grant high, then END pulse and return to idle.
    task automatic run_grant(input string tag, input logic [2:0] exp_en, input logic [17:0] exp_bus,
                             input int hold, input int which);
        tick();
        check_val({tag, "_en_entry"}, 32'(en), 32'(exp_en));
        check_val({tag, "_bus"}, 32'(bus), 32'(exp_bus));
        for (int i = 1; i < hold; i++) begin
            tick();
            check_val({tag, "_en_hold"}, 32'(en), 32'(exp_en));
        end
        case (which)
            0:       AREF_END = 1'b1;
            1:       WR_END   = 1'b1;
            default: RD_END   = 1'b1;
        endcase
        tick();
        AREF_END = 1'b0;
        WR_END   = 1'b0;
        RD_END   = 1'b0;
        check_val({tag, "_en_exit"}, 32'(en), 32'd0);
        check_val({tag, "_bus_exit"}, 32'(bus), 32'(NOP_BUS));
    endtask

    initial begin
        Rst_n = 1'b0;
        INIT_DONE = 1'b0;
        COMMAND_INIT = 4'b0010; INIT_A_ADDR = 12'h111; INIT_BANK_ADDR = 2'd1;
        AREF_CMD = 4'b0001; AREF_A_ADDR = 12'h222; AREF_BANK_ADDR = 2'd2;
        WR_CMD   = 4'b0100; WR_A_ADDR   = 12'h333; WR_BANK_ADDR   = 2'd3;
        RD_CMD   = 4'b0101; RD_A_ADDR   = 12'h444; RD_BANK_ADDR   = 2'd0;
        WR_REQ = 1'b0; RD_REQ = 1'b0;
        AREF_END = 1'b0; WR_END = 1'b0; RD_END = 1'b0;

        // Reset and init pass-through
        repeat (3) tick();
        check_val("rst_en", 32'(en), 32'd0);
        check_val("rst_bus", 32'(bus), 32'({4'b0010, 2'd1, 12'h111}));
        Rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            INIT_A_ADDR = 12'(i);
            tick();
            check_val("init_en", 32'(en), 32'd0);
            check_val("init_bus", 32'(bus), 32'({4'b0010, 2'd1, 12'(i)}));
        end
        INIT_A_ADDR = 12'h111;
        INIT_DONE = 1'b1;
        tick();
        INIT_DONE = 1'b0;
        check_val("idle_bus", 32'(bus), 32'(NOP_BUS));
        check_val("idle_en", 32'(en), 32'd0);

        // Refresh every 20 cycles with no requests
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("pre_aref1_en", 32'(en), 32'd0);
        end
        run_grant("aref1", 3'b100, AREF_BUS, 5, 0);
        for (int i = 0; i < 14; i++) begin
            tick();
            check_val("pre_aref2_en", 32'(en), 32'd0);
        end
        run_grant("aref2", 3'b100, AREF_BUS, 1, 0);

        // Round-robin with both requests held; expiry during the second read
        WR_REQ = 1'b1;
        RD_REQ = 1'b1;
        run_grant("rr_wr1", 3'b010, WR_BUS, 4, 1);
        run_grant("rr_rd1", 3'b001, RD_BUS, 4, 2);
        run_grant("rr_wr2", 3'b010, WR_BUS, 4, 1);
        run_grant("rr_rd2", 3'b001, RD_BUS, 4, 2);
        run_grant("rr_aref", 3'b100, AREF_BUS, 1, 0);

        // Long write: stray ENDs ignored, expiry mid-write, refresh before next read
        tick();
        check_val("lw_en_entry", 32'(en), 32'b010);
        RD_END = 1'b1;
        AREF_END = 1'b1;
        tick();
        RD_END = 1'b0;
        AREF_END = 1'b0;
        check_val("stray_end_en", 32'(en), 32'b010);
        check_val("stray_end_bus", 32'(bus), 32'(WR_BUS));
        for (int i = 0; i < 15; i++) begin
            tick();
            check_val("lw_en_hold", 32'(en), 32'b010);
        end
        WR_END = 1'b1;
        tick();
        WR_END = 1'b0;
        check_val("lw_en_exit", 32'(en), 32'd0);
        tick();
        check_val("aref_after_wr_en", 32'(en), 32'b100);
        check_val("aref_after_wr_bus", 32'(bus), 32'(AREF_BUS));
        AREF_END = 1'b1;
        tick();
        AREF_END = 1'b0;
        check_val("aref3_exit_en", 32'(en), 32'd0);
        tick();
        check_val("rd_after_aref_en", 32'(en), 32'b001);
        repeat (2) tick();
        check_val("rd_mid_en", 32'(en), 32'b001);

        // Asynchronous reset mid-read
        #2;
        Rst_n = 1'b0;
        #1;
        check_val("async_rst_en", 32'(en), 32'd0);
        check_val("async_rst_bus", 32'(bus), 32'(init_bus));
        WR_REQ = 1'b0;
        RD_REQ = 1'b0;
        tick();
        Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("post_rst_en", 32'(en), 32'd0);
        end
        INIT_DONE = 1'b1;
        tick();
        INIT_DONE = 1'b0;
        check_val("reinit_bus", 32'(bus), 32'(NOP_BUS));
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("timer_restart_en", 32'(en), 32'd0);
        end
        tick();
        check_val("timer_restart_aref", 32'(en), 32'b100);
        AREF_END = 1'b1;
        tick();
        AREF_END = 1'b0;
        WR_REQ = 1'b1;
        RD_REQ = 1'b1;
        tick();
        check_val("post_rst_tie_wr", 32'(en), 32'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
